// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch time counter: run-state encoding,
// BCD digit type, per-digit limits and the packed MM:SS.cc time record.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUNNING  = 2'd1,
    STOPPED  = 2'd2,
    OVERFLOW = 2'd3
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_DEC  = 4'd9;
  localparam bcd_t BCD_MAX_SEXT = 4'd5;

  typedef struct packed {
    bcd_t m_tens;
    bcd_t m_ones;
    bcd_t s_tens;
    bcd_t s_ones;
    bcd_t cs_tens;
    bcd_t cs_ones;
  } sw_time_t;

  // Value a digit will hold after this edge, wrapping to zero past max.
  function automatic bcd_t bcd_next(bcd_t d, logic inc, bcd_t max);
    if (!inc)
      return d;
    else if (d == max)
      return 4'd0;
    else
      return d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit counting 0..MODMAX; carry is combinational so a whole chain of
// these advances in a single clock edge.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter bcd_t MODMAX = BCD_MAX_DEC
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  always_ff @(posedge clock) begin
    if (reset || clr)
      digit <= 4'd0;
    else
      digit <= bcd_next(digit, inc, MODMAX);
  end

  assign carry = inc && (digit == MODMAX);

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch run/stop/clear control and MM:SS.cc BCD accumulator.
// Optional lap-hold display is built when STOPWATCH_LAP_EN is defined.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int MIN_LIMIT = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic       run,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] s_ones,
  output logic [3:0] s_tens,
  output logic [3:0] m_ones,
  output logic [3:0] m_tens,
  output logic       overflow
);

  generate
    if (MIN_LIMIT < 1 || MIN_LIMIT > 99) begin : g_bad_min_limit
      $error("stopwatch_time_counter: MIN_LIMIT must be in 1..99");
    end
  endgenerate

  localparam bcd_t LIM_TENS = bcd_t'(MIN_LIMIT / 10);
  localparam bcd_t LIM_ONES = bcd_t'(MIN_LIMIT % 10);

  sw_state_t state, next_state;
  sw_time_t  live;
  logic      clr_digits;
  logic      count_en, at_max, inc_cs, ovf_hit;
  logic      c_cs_ones, c_cs_tens, c_s_ones, c_s_tens;
  bcd_t      m_ones_nxt, m_tens_nxt;
  logic      m_tens_inc;

  // ---------------------------------------------------------------------------
  // Control state machine
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // NOTE: every output of this block is defaulted first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    clr_digits = 1'b0;
    unique case (state)
      IDLE:     if (start_stop) next_state = RUNNING;
      RUNNING: begin
        if (ovf_hit)
          next_state = OVERFLOW;
        else if (start_stop)
          next_state = STOPPED;
      end
      STOPPED: begin
        if (clear) begin
          next_state = IDLE;
          clr_digits = 1'b1;
        end else if (start_stop) begin
          next_state = RUNNING;
        end
      end
      OVERFLOW: begin
        if (clear) begin
          next_state = IDLE;
          clr_digits = 1'b1;
        end
      end
      default:  next_state = IDLE;
    endcase
  end

  assign run      = (state == RUNNING);
  assign overflow = (state == OVERFLOW);

  // ---------------------------------------------------------------------------
  // Time accumulator
  // ---------------------------------------------------------------------------
  // A tick at the top count saturates instead of wrapping, so the first digit
  // is never enabled there and the whole chain holds.
  assign at_max   = (live.m_tens == LIM_TENS) && (live.m_ones == LIM_ONES) &&
                    (live.s_tens == BCD_MAX_SEXT) && (live.s_ones == BCD_MAX_DEC) &&
                    (live.cs_tens == BCD_MAX_DEC) && (live.cs_ones == BCD_MAX_DEC);
  assign count_en = tick && (state == RUNNING);
  assign inc_cs   = count_en && !at_max;
  assign ovf_hit  = count_en && at_max;

  bcd_digit_counter #(.MODMAX(BCD_MAX_DEC)) u_cs_ones (
    .clock(clock), .reset(reset), .clr(clr_digits),
    .inc(inc_cs), .digit(live.cs_ones), .carry(c_cs_ones)
  );

  bcd_digit_counter #(.MODMAX(BCD_MAX_DEC)) u_cs_tens (
    .clock(clock), .reset(reset), .clr(clr_digits),
    .inc(c_cs_ones), .digit(live.cs_tens), .carry(c_cs_tens)
  );

  bcd_digit_counter #(.MODMAX(BCD_MAX_DEC)) u_s_ones (
    .clock(clock), .reset(reset), .clr(clr_digits),
    .inc(c_cs_tens), .digit(live.s_ones), .carry(c_s_ones)
  );

  bcd_digit_counter #(.MODMAX(BCD_MAX_SEXT)) u_s_tens (
    .clock(clock), .reset(reset), .clr(clr_digits),
    .inc(c_s_ones), .digit(live.s_tens), .carry(c_s_tens)
  );

  // Minutes live here because the limit compare spans both digits.
  assign m_tens_inc = c_s_tens && (live.m_ones == BCD_MAX_DEC);
  assign m_ones_nxt = bcd_next(live.m_ones, c_s_tens, BCD_MAX_DEC);
  assign m_tens_nxt = bcd_next(live.m_tens, m_tens_inc, BCD_MAX_DEC);

  always_ff @(posedge clock) begin
    if (reset || clr_digits) begin
      live.m_ones <= 4'd0;
      live.m_tens <= 4'd0;
    end else begin
      live.m_ones <= m_ones_nxt;
      live.m_tens <= m_tens_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Display selection
  // ---------------------------------------------------------------------------
  sw_time_t shown;

`ifdef STOPWATCH_LAP_EN
  sw_time_t live_nxt;
  sw_time_t held_q;
  logic     hold_q;
  logic     release_hold;
  logic     lap_run;

  // Post-edge count, so a lap sampled with a tick captures that tick.
  always_comb begin
    live_nxt         = live;
    live_nxt.cs_ones = bcd_next(live.cs_ones, inc_cs,    BCD_MAX_DEC);
    live_nxt.cs_tens = bcd_next(live.cs_tens, c_cs_ones, BCD_MAX_DEC);
    live_nxt.s_ones  = bcd_next(live.s_ones,  c_cs_tens, BCD_MAX_DEC);
    live_nxt.s_tens  = bcd_next(live.s_tens,  c_s_ones,  BCD_MAX_SEXT);
    live_nxt.m_ones  = m_ones_nxt;
    live_nxt.m_tens  = m_tens_nxt;
  end

  assign lap_run      = lap && (state == RUNNING);
  assign release_hold = clr_digits || ((state == RUNNING) && (next_state != RUNNING));

  always_ff @(posedge clock) begin
    if (reset || release_hold)
      hold_q <= 1'b0;
    else if (lap_run)
      hold_q <= ~hold_q;
  end

  // NOTE: the held copy is deliberately not reset; it is only visible while
  // hold_q is set, and hold_q is always loaded together with it.
  always_ff @(posedge clock) begin
    if (lap_run && !hold_q)
      held_q <= live_nxt;
  end

  assign shown = hold_q ? held_q : live;
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign shown      = live;
`endif

  assign cs_ones = shown.cs_ones;
  assign cs_tens = shown.cs_tens;
  assign s_ones  = shown.s_ones;
  assign s_tens  = shown.s_tens;
  assign m_ones  = shown.m_ones;
  assign m_tens  = shown.m_tens;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench for stopwatch_time_counter built with MIN_LIMIT = 2 so the
// overflow boundary is reachable; the lap scenario follows STOPWATCH_LAP_EN.
module tb_stopwatch_time_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic       run, overflow;
  logic [3:0] cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens;

  int total = 0;
  int bad   = 0;

  stopwatch_time_counter #(.MIN_LIMIT(2)) dut (
    .clock(clock), .reset(reset), .tick(tick), .start_stop(start_stop),
    .clear(clear), .lap(lap), .run(run),
    .cs_ones(cs_ones), .cs_tens(cs_tens), .s_ones(s_ones), .s_tens(s_tens),
    .m_ones(m_ones), .m_tens(m_tens), .overflow(overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [23:0] digits();
    return {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones};
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic tick_n(input int n);
    tick = 1'b1;
    cycles(n);
    tick = 1'b0;
  endtask

  task automatic press_start();
    start_stop = 1'b1;
    cycles(1);
    start_stop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (digits() !== 24'h000000) begin bad++; $display("FAIL reset_digits: got %h want %h", digits(), 24'h000000); end
    total++; if (run !== 1'b0) begin bad++; $display("FAIL reset_run: got %b want 0", run); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_idle_drops();
    do_reset();
    tick_n(5);
    total++; if (digits() !== 24'h000000) begin bad++; $display("FAIL idle_ticks_dropped: got %h want %h", digits(), 24'h000000); end
    clear = 1'b1; start_stop = 1'b1;
    cycles(1);
    clear = 1'b0; start_stop = 1'b0;
    total++; if (run !== 1'b1) begin bad++; $display("FAIL idle_start_beats_clear: run got %b want 1", run); end
  endtask

  task automatic test_count();
    do_reset();
    press_start();
    total++; if (run !== 1'b1) begin bad++; $display("FAIL start_run: got %b want 1", run); end
    tick_n(100);
    total++; if (digits() !== 24'h000100) begin bad++; $display("FAIL count_100: got %h want %h", digits(), 24'h000100); end
    total++; if ({cs_tens, cs_ones} !== 8'h00) begin bad++; $display("FAIL count_cs_zero: got %h want 00", {cs_tens, cs_ones}); end
  endtask

  task automatic test_minute_carry();
    tick_n(5899);
    total++; if (digits() !== 24'h005999) begin bad++; $display("FAIL pre_minute: got %h want %h", digits(), 24'h005999); end
    tick_n(1);
    total++; if (digits() !== 24'h010000) begin bad++; $display("FAIL minute_carry: got %h want %h", digits(), 24'h010000); end
  endtask

  task automatic test_stop_and_clear();
    do_reset();
    press_start();
    tick_n(5);
    total++; if (digits() !== 24'h000005) begin bad++; $display("FAIL run_5: got %h want %h", digits(), 24'h000005); end
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    total++; if (digits() !== 24'h000005 || run !== 1'b1) begin bad++; $display("FAIL clear_while_running: got %h run %b want %h run 1", digits(), run, 24'h000005); end
    tick = 1'b1; start_stop = 1'b1;
    cycles(1);
    tick = 1'b0; start_stop = 1'b0;
    total++; if (digits() !== 24'h000006 || run !== 1'b0) begin bad++; $display("FAIL tick_with_stop: got %h run %b want %h run 0", digits(), run, 24'h000006); end
    tick_n(10);
    total++; if (digits() !== 24'h000006) begin bad++; $display("FAIL stopped_ticks_dropped: got %h want %h", digits(), 24'h000006); end
    press_start();
    tick_n(3);
    total++; if (digits() !== 24'h000009 || run !== 1'b1) begin bad++; $display("FAIL resume: got %h run %b want %h run 1", digits(), run, 24'h000009); end
    press_start();
    clear = 1'b1; start_stop = 1'b1;
    cycles(1);
    clear = 1'b0; start_stop = 1'b0;
    total++; if (digits() !== 24'h000000 || run !== 1'b0) begin bad++; $display("FAIL stopped_clear_beats_start: got %h run %b want %h run 0", digits(), run, 24'h000000); end
  endtask

  task automatic test_overflow();
    do_reset();
    press_start();
    tick_n(17999);
    total++; if (digits() !== 24'h025999 || run !== 1'b1) begin bad++; $display("FAIL pre_overflow: got %h run %b want %h run 1", digits(), run, 24'h025999); end
    tick_n(1);
    total++; if (digits() !== 24'h025999) begin bad++; $display("FAIL overflow_hold: got %h want %h", digits(), 24'h025999); end
    total++; if (overflow !== 1'b1 || run !== 1'b0) begin bad++; $display("FAIL overflow_flags: overflow %b run %b want overflow 1 run 0", overflow, run); end
    tick_n(1);
    press_start();
    total++; if (digits() !== 24'h025999 || overflow !== 1'b1 || run !== 1'b0) begin bad++; $display("FAIL overflow_ignores: got %h ovf %b run %b want %h ovf 1 run 0", digits(), overflow, run, 24'h025999); end
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    total++; if (digits() !== 24'h000000 || overflow !== 1'b0) begin bad++; $display("FAIL overflow_clear: got %h ovf %b want %h ovf 0", digits(), overflow, 24'h000000); end
    press_start();
    total++; if (run !== 1'b1) begin bad++; $display("FAIL restart_after_clear: run got %b want 1", run); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_start();
    tick_n(1234);
    total++; if (digits() !== 24'h001234) begin bad++; $display("FAIL mid_count: got %h want %h", digits(), 24'h001234); end
    reset = 1'b1; start_stop = 1'b1; tick = 1'b1;
    cycles(1);
    reset = 1'b0; start_stop = 1'b0; tick = 1'b0;
    total++; if (digits() !== 24'h000000 || run !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL reset_mid: got %h run %b ovf %b want %h run 0 ovf 0", digits(), run, overflow, 24'h000000); end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    do_reset();
    press_start();
    tick_n(300);
    lap = 1'b1;
    cycles(1);
    lap = 1'b0;
    tick_n(50);
    total++; if (digits() !== 24'h000300) begin bad++; $display("FAIL lap_hold: got %h want %h", digits(), 24'h000300); end
    lap = 1'b1;
    cycles(1);
    lap = 1'b0;
    total++; if (digits() !== 24'h000350) begin bad++; $display("FAIL lap_release: got %h want %h", digits(), 24'h000350); end
    lap = 1'b1; tick = 1'b1;
    cycles(1);
    lap = 1'b0; tick = 1'b0;
    total++; if (digits() !== 24'h000351) begin bad++; $display("FAIL lap_with_tick: got %h want %h", digits(), 24'h000351); end
    tick_n(5);
    total++; if (digits() !== 24'h000351) begin bad++; $display("FAIL lap_hold2: got %h want %h", digits(), 24'h000351); end
    press_start();
    total++; if (digits() !== 24'h000356) begin bad++; $display("FAIL lap_release_on_stop: got %h want %h", digits(), 24'h000356); end
    lap = 1'b1;
    cycles(1);
    lap = 1'b0;
    press_start();
    tick_n(4);
    total++; if (digits() !== 24'h000360) begin bad++; $display("FAIL lap_ignored_stopped: got %h want %h", digits(), 24'h000360); end
  endtask
`else
  task automatic test_lap();
    do_reset();
    press_start();
    tick_n(3);
    lap = 1'b1; tick = 1'b1;
    cycles(1);
    lap = 1'b0; tick = 1'b0;
    tick_n(2);
    total++; if (digits() !== 24'h000006) begin bad++; $display("FAIL lap_ignored: got %h want %h", digits(), 24'h000006); end
  endtask
`endif

  initial begin
    test_reset();
    test_idle_drops();
    test_count();
    test_minute_carry();
    test_stop_and_clear();
    test_overflow();
    test_reset_mid();
    test_lap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
